// File: rtl/pwm_cap_pkg.sv
// Shared types and helpers for the PWM duty-capture monitor.
package pwm_cap_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        STALL
    } cap_state_t;

    // Increment v by one when inc is set, holding at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc,
                                            input logic [31:0] max);
        return (inc && (v < max)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pwm_duty_capture_if.sv
// Measurement handshake bus between the capture block and its consumer.
interface pwm_duty_capture_if #(
    parameter int unsigned D_WIDTH = 19
);
    logic [D_WIDTH-1:0] period_out;
    logic [D_WIDTH-1:0] dutyA_out;
    logic [D_WIDTH-1:0] dutyB_out;
    logic [D_WIDTH-1:0] dutyC_out;
    logic               valid_out;
    logic               ready_in;
    logic               overrun_out;
    logic               stall_out;

    modport master (
        output period_out, dutyA_out, dutyB_out, dutyC_out,
        output valid_out, overrun_out, stall_out,
        input  ready_in
    );

    modport slave (
        input  period_out, dutyA_out, dutyB_out, dutyC_out,
        input  valid_out, overrun_out, stall_out,
        output ready_in
    );
endinterface

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for one PWM phase plus a delay flop for edge detection.
module pwm_in_sync
    import pwm_cap_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic pwm,
    output logic s2,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm};
            dly  <= sync[SYNC_STAGES-1];
        end
    end

    assign s2   = sync[SYNC_STAGES-1];
    assign rise = s2 & ~dly;
endmodule

// File: rtl/pwm_duty_capture.sv
// Measures phase-A PWM period and per-phase high time, one result per window,
// presented on a valid/ready bus with overrun and stall flags.
module pwm_duty_capture
    import pwm_cap_pkg::*;
#(
    parameter int unsigned D_WIDTH = 19
) (
    input  logic clk,
    input  logic rstb,
    input  logic pwmA_in,
    input  logic pwmB_in,
    input  logic pwmC_in,
    pwm_duty_capture_if.master meas
);
    localparam logic [D_WIDTH-1:0] CNT_MAX = '1;

    logic [2:0]         s2;
    logic               rise_a;
    logic               rise_b;
    logic               rise_c;
    logic               unused_rise_bc;
    logic               det;
    logic [D_WIDTH-1:0] win_cnt;
    logic [D_WIDTH-1:0] hi_cnt [3];
    cap_state_t         state;

    pwm_in_sync u_sync_a (.clk(clk), .rstb(rstb), .pwm(pwmA_in), .s2(s2[0]), .rise(rise_a));
    pwm_in_sync u_sync_b (.clk(clk), .rstb(rstb), .pwm(pwmB_in), .s2(s2[1]), .rise(rise_b));
    pwm_in_sync u_sync_c (.clk(clk), .rstb(rstb), .pwm(pwmC_in), .s2(s2[2]), .rise(rise_c));

    // Only phase A defines the measurement window.
    assign unused_rise_bc = rise_b | rise_c;
    assign det            = rise_a;

    function automatic logic [D_WIDTH-1:0] bump(input logic [D_WIDTH-1:0] v, input logic inc);
        return D_WIDTH'(sat_inc(32'(v), inc, 32'(CNT_MAX)));
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state            <= IDLE;
            win_cnt          <= '0;
            for (int unsigned i = 0; i < 3; i++) hi_cnt[i] <= '0;
            meas.period_out  <= '0;
            meas.dutyA_out   <= '0;
            meas.dutyB_out   <= '0;
            meas.dutyC_out   <= '0;
            meas.valid_out   <= 1'b0;
            meas.overrun_out <= 1'b0;
            meas.stall_out   <= 1'b0;
        end else begin
            meas.overrun_out <= 1'b0;
            if (meas.valid_out && meas.ready_in) meas.valid_out <= 1'b0;

            if (det) begin
                win_cnt <= D_WIDTH'(1);
                for (int unsigned i = 0; i < 3; i++) hi_cnt[i] <= D_WIDTH'(s2[i]);
                // Only ARMED holds a complete window; IDLE and STALL just re-arm.
                if (state == ARMED) begin
                    meas.period_out  <= win_cnt;
                    meas.dutyA_out   <= hi_cnt[0];
                    meas.dutyB_out   <= hi_cnt[1];
                    meas.dutyC_out   <= hi_cnt[2];
                    meas.valid_out   <= 1'b1;
                    meas.overrun_out <= meas.valid_out & ~meas.ready_in;
                end
                state          <= ARMED;
                meas.stall_out <= 1'b0;
            end else begin
                win_cnt <= bump(win_cnt, 1'b1);
                for (int unsigned i = 0; i < 3; i++) hi_cnt[i] <= bump(hi_cnt[i], s2[i]);
                if ((state == ARMED) && (win_cnt == CNT_MAX - 1'b1)) begin
                    state          <= STALL;
                    meas.stall_out <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/pwm_duty_capture.md
# pwm_duty_capture

Receive-side monitor for the three-phase PWM outputs of the FOC controller. It synchronizes pwmA/B/C, measures the PWM period from phase-A rising edges, and counts the high time of each phase per period. Each completed measurement is presented on a valid/ready handshake. It is used for closed-loop verification, for duty readback to the ECU, and for stall detection on the PWM generator.

## Interface
- D_WIDTH, 19, width of the period and high-time counters and outputs
- clk  in  1  system clock, all logic on the rising edge
- rstb  in  1  asynchronous active-low reset
- pwmA_in, pwmB_in, pwmC_in  in  1 each  PWM phase inputs, treated as asynchronous
- period_out  out  D_WIDTH  clocks between consecutive phase-A rising edges
- dutyA_out, dutyB_out, dutyC_out  out  D_WIDTH each  high-clock count per phase within that period
- valid_out  out  1  measurement available
- ready_in  in  1  consumer accepts the measurement
- overrun_out  out  1  one-cycle pulse when an unaccepted measurement is overwritten
- stall_out  out  1  level, no phase-A rising edge for 2^D_WIDTH−1 clocks

## Operation
- **Synchronizer:** each input passes through a 2-flop synchronizer (s1, s2), then a delay flop (s3). All counting uses the s2 values.
- **Rising-edge detect:** `det` = a_s2 & ~a_s3.
- **Counting:** every non-det cycle, win_cnt += 1 and hi_x += x_s2. Both saturate at 2^D_WIDTH−1 and never wrap.
- **On det:**
  - win_cnt <= 1 and hi_x <= x_s2.
  - If `armed`, latch period_out <= win_cnt and duty_x_out <= hi_x, then set valid_out.
  - Always set armed <= 1 and clear stall_out.
- **Window definition:** a window spans the det cycle through the cycle before the next det. Therefore duty_x_out ≤ period_out always holds, and dutyA_out ≥ 1.
- **After reset:** armed = 0, so the first det only arms and produces no output.
- **State machine** (IDLE, ARMED, STALL):
  - IDLE → ARMED on det.
  - ARMED → STALL when win_cnt reaches its maximum.
  - STALL → ARMED on det. This det emits nothing, because the window is invalid. armed is cleared on entry to STALL.
- **Handshake:**
  - A measurement transfers on a clock edge where valid_out & ready_in.
  - valid_out clears on transfer unless a new measurement loads in the same cycle, in which case it stays 1 and the new data is presented.
  - Outputs hold stable while valid_out & ~ready_in.
- **Overrun:** if det with armed occurs while valid_out=1 and ready_in=0, the new data overwrites the old, valid_out stays 1, and overrun_out pulses for 1 cycle.
- **Reset mid-operation:** all counters, flags and outputs clear immediately (asynchronous). Measurement restarts unarmed.

## Timing
- **Reset values:**
  - period_out, dutyA_out, dutyB_out and dutyC_out = 0.
  - valid_out, overrun_out and stall_out = 0.
  - Synchronizer flops = 0.
- **Latency:** a pwmA_in rise first sampled at edge k gives det during cycle k+1 to k+2. valid_out and the new data appear after edge k+2.
- **Phase skew:** all phases have identical synchronizer latency, so phase-to-phase skew is preserved exactly.
- **stall_out:** rises on the edge where win_cnt becomes 2^D_WIDTH−1.
- **overrun_out:** registered, asserted coincident with the overwritten data.
- **Minimum period:** 2 clocks. A shorter period is undefined.

## Structure
- **Package pwm_cap_pkg:** SYNC_STAGES=2, the state enum typedef {IDLE, ARMED, STALL}, and the saturating-increment function.
- **Sub-module pwm_in_sync:** 2-flop synchronizer plus delay flop, with s2 and rise outputs. Instantiated three times; only phase A's rise output is used.
- **Top level:** window counter, three high counters, output registers and handshake logic live in pwm_duty_capture.

## Test plan
- **Basic measurement:** A/B/C high for 50/25/75 of 100 clocks, ready_in=1 → no valid on the first A edge; then period=100, duties 50/25/75 each period, one valid per period.
- **Duty extremes:** B held high, C held low, period 64 → dutyB=64, dutyC=0.
- **Overrun:** ready_in=0 across two windows of periods 100 then 120 → overrun_out pulses once; period_out=120 is held; raising ready_in clears valid after one edge.
- **Stall:** D_WIDTH=8, A stuck low after one window → stall_out after 255 clocks with no valid; the next A edge clears stall with no output, and the following edge gives a valid measurement.
- **Reset mid-window:** rstb low for 1 cycle partway through a window → all outputs 0 immediately; the first post-reset edge only arms.
- **Simultaneous events:** ready_in=1 and det in the same cycle while valid=1 → old data transferred, new data presented, valid stays 1, no overrun.
